// File: rtl/spu_pipe_pkg.sv
// rtl/spu_pipe_pkg.sv - shared types and helpers for the SPU result-staging pipeline
package spu_pipe_pkg;

  localparam int REG_ADDR_W = 7;
  localparam int UID_W      = 3;
  localparam int RT_MAX_W   = 128;

  // rt is sized for the widest pipe; narrower DATA_W builds use the low bits.
  typedef struct packed {
    logic                  valid;
    logic                  wreg;
    logic [REG_ADDR_W-1:0] rtaddr;
    logic [RT_MAX_W-1:0]   rt;
    logic [UID_W-1:0]      uid;
  } spu_result_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spu_result_stage.sv
// rtl/spu_result_stage.sv - one pipeline stage holding a result entry per issue pipe
module spu_result_stage
  import spu_pipe_pkg::*;
#(
  parameter int NUM_PIPES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic                          kill,
  input  spu_result_t [NUM_PIPES-1:0]   d,
  output spu_result_t [NUM_PIPES-1:0]   q,
  output spu_result_t [NUM_PIPES-1:0]   q_next
);

  // Kill applies after the hold/advance choice, so a stalled flush clears in place.
  always_comb begin
    q_next = hold ? q : d;
    if (kill) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        q_next[p].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

endmodule

// File: rtl/spu_result_pipe.sv
// rtl/spu_result_pipe.sv - DEPTH-stage SPU writeback staging with stall, partial flush, forwarding
// Forwarding lookup is built only when SPU_RESULT_PIPE_LOOKUP_EN is defined.
module spu_result_pipe
  import spu_pipe_pkg::*;
#(
  parameter int NUM_PIPES    = 2,
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 128,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     stall,
  input  logic                                     flush,
  input  logic [NUM_PIPES-1:0]                     in_valid,
  input  logic [NUM_PIPES-1:0]                     in_wreg,
  input  logic [NUM_PIPES*REG_ADDR_W-1:0]          in_rtaddr,
  input  logic [NUM_PIPES*DATA_W-1:0]              in_rt,
  input  logic [NUM_PIPES*UID_W-1:0]               in_uid,
  output logic [NUM_PIPES-1:0]                     out_valid,
  output logic [NUM_PIPES-1:0]                     out_wreg,
  output logic [NUM_PIPES*REG_ADDR_W-1:0]          out_rtaddr,
  output logic [NUM_PIPES*DATA_W-1:0]              out_rt,
  output logic [NUM_PIPES*UID_W-1:0]               out_uid,
  output logic [clog2(DEPTH*NUM_PIPES+1)-1:0]      occupancy,
  input  logic [NUM_PIPES*REG_ADDR_W-1:0]          lk_addr,
  output logic [NUM_PIPES-1:0]                     lk_hit,
  output logic [NUM_PIPES*DATA_W-1:0]              lk_data
);

  localparam int OCC_W = clog2(DEPTH*NUM_PIPES+1);

  spu_result_t [NUM_PIPES-1:0] in_pack;
  spu_result_t [NUM_PIPES-1:0] stage_d [DEPTH];
  spu_result_t [NUM_PIPES-1:0] stage_q [DEPTH];
  spu_result_t [NUM_PIPES-1:0] stage_n [DEPTH];
  logic [OCC_W-1:0]            occ_next;
  spu_result_t                 tail;

  always_comb begin
    in_pack = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      in_pack[p].valid  = in_valid[p];
      in_pack[p].wreg   = in_wreg[p];
      in_pack[p].rtaddr = in_rtaddr[p*REG_ADDR_W +: REG_ADDR_W];
      in_pack[p].rt     = RT_MAX_W'(in_rt[p*DATA_W +: DATA_W]);
      in_pack[p].uid    = in_uid[p*UID_W +: UID_W];
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign stage_d[s] = in_pack;
    end else begin : g_body
      assign stage_d[s] = stage_q[s-1];
    end

    spu_result_stage #(
      .NUM_PIPES (NUM_PIPES)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .hold   (stall),
      .kill   (flush && (s < FLUSH_STAGES)),
      .d      (stage_d[s]),
      .q      (stage_q[s]),
      .q_next (stage_n[s])
    );
  end

  // Counted from next-state valids so occupancy lines up with the registered stages.
  always_comb begin
    occ_next = '0;
    for (int s = 0; s < DEPTH; s++) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        occ_next = occ_next + OCC_W'(stage_n[s][p].valid);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy <= '0;
    else     occupancy <= occ_next;
  end

  always_comb begin
    out_valid  = '0;
    out_wreg   = '0;
    out_rtaddr = '0;
    out_rt     = '0;
    out_uid    = '0;
    tail       = '0;
    for (int p = 0; p < NUM_PIPES; p++) begin
      tail         = stage_q[DEPTH-1][p];
      out_valid[p] = tail.valid;
      out_wreg[p]  = tail.valid & tail.wreg;
      if (tail.valid) begin
        out_rtaddr[p*REG_ADDR_W +: REG_ADDR_W] = tail.rtaddr;
        out_rt[p*DATA_W +: DATA_W]             = tail.rt[DATA_W-1:0];
        out_uid[p*UID_W +: UID_W]              = tail.uid;
      end
    end
  end

`ifdef SPU_RESULT_PIPE_LOOKUP_EN
  // Scan oldest to youngest so the last match (lowest stage, highest pipe) wins.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int r = 0; r < NUM_PIPES; r++) begin
      for (int s = DEPTH-1; s >= 0; s--) begin
        for (int p = 0; p < NUM_PIPES; p++) begin
          if (stage_q[s][p].valid && stage_q[s][p].wreg &&
              stage_q[s][p].rtaddr == lk_addr[r*REG_ADDR_W +: REG_ADDR_W]) begin
            lk_hit[r]                   = 1'b1;
            lk_data[r*DATA_W +: DATA_W] = stage_q[s][p].rt[DATA_W-1:0];
          end
        end
      end
    end
  end
`else
  logic unused_lk_addr;
  assign unused_lk_addr = ^lk_addr;
  assign lk_hit         = '0;
  assign lk_data        = '0;
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
// tb/tb_spu_result_pipe.sv - self-checking bench for spu_result_pipe against a transaction-age model
module tb_spu_result_pipe;

  localparam int NP    = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 128;
  localparam int FS    = 2;

  logic             clk = 1'b0;
  logic             rst, stall, flush;
  logic [NP-1:0]    in_valid, in_wreg;
  logic [NP*7-1:0]  in_rtaddr;
  logic [NP*DW-1:0] in_rt;
  logic [NP*3-1:0]  in_uid;
  logic [NP-1:0]    out_valid, out_wreg;
  logic [NP*7-1:0]  out_rtaddr;
  logic [NP*DW-1:0] out_rt;
  logic [NP*3-1:0]  out_uid;
  logic [3:0]       occupancy;
  logic [NP*7-1:0]  lk_addr;
  logic [NP-1:0]    lk_hit;
  logic [NP*DW-1:0] lk_data;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;
  bit rec    = 0;
  logic [6:0] seen[$];

  always #5 clk = ~clk;

  spu_result_pipe #(
    .NUM_PIPES(NP), .DEPTH(DEPTH), .DATA_W(DW), .FLUSH_STAGES(FS)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_rtaddr(in_rtaddr), .in_rt(in_rt), .in_uid(in_uid),
    .out_valid(out_valid), .out_wreg(out_wreg), .out_rtaddr(out_rtaddr), .out_rt(out_rt),
    .out_uid(out_uid), .occupancy(occupancy),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data)
  );

  // Model: each live result is a transaction tagged with its age (stages travelled).
  typedef struct {
    int          pipe;
    int          age;
    bit          wreg;
    bit [6:0]    addr;
    bit [DW-1:0] data;
    bit [2:0]    uid;
  } ent_t;
  ent_t mdl[$];

  function automatic void model_step();
    ent_t nq[$];
    ent_t e;
    if (rst) begin
      mdl.delete();
      return;
    end
    if (stall) nq = mdl;
    else begin
      foreach (mdl[i]) begin
        e = mdl[i];
        e.age++;
        if (e.age < DEPTH) nq.push_back(e);
      end
      for (int p = 0; p < NP; p++) begin
        if (in_valid[p]) begin
          e.pipe = p; e.age = 0; e.wreg = in_wreg[p];
          e.addr = in_rtaddr[p*7 +: 7]; e.data = in_rt[p*DW +: DW]; e.uid = in_uid[p*3 +: 3];
          nq.push_back(e);
        end
      end
    end
    if (flush) begin
      mdl.delete();
      foreach (nq[i]) if (nq[i].age >= FS) mdl.push_back(nq[i]);
    end else mdl = nq;
  endfunction

  always @(posedge clk) begin
    if (rec && !rst && !stall && out_valid[0]) seen.push_back(out_rtaddr[6:0]);
    model_step();
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [NP-1:0]    ev, ew, eh;
    logic [NP*7-1:0]  ea;
    logic [NP*DW-1:0] ed, eld;
    logic [NP*3-1:0]  eu;
    int ba, bp;
    ev = '0; ew = '0; ea = '0; ed = '0; eu = '0; eh = '0; eld = '0;
    foreach (mdl[i]) begin
      if (mdl[i].age == DEPTH-1) begin
        ev[mdl[i].pipe] = 1'b1;
        ew[mdl[i].pipe] = mdl[i].wreg;
        ea[mdl[i].pipe*7 +: 7]   = mdl[i].addr;
        ed[mdl[i].pipe*DW +: DW] = mdl[i].data;
        eu[mdl[i].pipe*3 +: 3]   = mdl[i].uid;
      end
    end
`ifdef SPU_RESULT_PIPE_LOOKUP_EN
    for (int r = 0; r < NP; r++) begin
      ba = DEPTH; bp = -1;
      foreach (mdl[i]) begin
        if (mdl[i].wreg && mdl[i].addr == lk_addr[r*7 +: 7] &&
            (mdl[i].age < ba || (mdl[i].age == ba && mdl[i].pipe > bp))) begin
          ba = mdl[i].age; bp = mdl[i].pipe;
          eh[r] = 1'b1;
          eld[r*DW +: DW] = mdl[i].data;
        end
      end
    end
`endif
    chk("out_valid", out_valid, ev);
    chk("out_wreg", out_wreg, ew);
    chk("out_rtaddr", out_rtaddr, ea);
    chk("out_rt", out_rt, ed);
    chk("out_uid", out_uid, eu);
    chk("occupancy", occupancy, mdl.size());
    chk("lk_hit", lk_hit, eh);
    chk("lk_data", lk_data, eld);
  endtask

  always @(negedge clk) if (chk_en) check_all();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit v, input bit w, input int a,
                       input logic [DW-1:0] d, input int u);
    in_valid[p] = v; in_wreg[p] = w; in_rtaddr[p*7 +: 7] = 7'(a);
    in_rt[p*DW +: DW] = d; in_uid[p*3 +: 3] = 3'(u);
  endtask

  task automatic clear_in();
    in_valid = '0; in_wreg = '0; in_rtaddr = '0; in_rt = '0; in_uid = '0;
  endtask

  task automatic drive_pair(input int base);
    drive(0, 1, 1, base,      {4{32'h1000_0000 + 32'(base)}}, base);
    drive(1, 1, 1, base + 40, {4{32'h2000_0000 + 32'(base)}}, base + 1);
  endtask

  logic [NP*DW-1:0] frozen;
  logic [DW-1:0]    hit_exp0, hit_exp1;

  initial begin
    rst = 1; stall = 0; flush = 0; lk_addr = '0;
    clear_in();
    tick(); tick();
    chk_en = 1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_out_rt", out_rt, 0);
    rst = 0;

    // 1: single pair through the default-depth pipe
    drive(0, 1, 1, 5, {16{8'hA5}}, 1);
    drive(1, 1, 1, 6, {16{8'h5A}}, 2);
    tick();
    clear_in();
    chk("t1_occ_flight", occupancy, 2);
    tick(); tick();
    chk("t1_not_yet", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 2'b11);
    chk("t1_out_addr", out_rtaddr, {7'd6, 7'd5});
    chk("t1_out_rt0", out_rt[DW-1:0], {16{8'hA5}});
    chk("t1_occ", occupancy, 2);
    tick();
    chk("t1_drained_valid", out_valid, 0);
    chk("t1_drained_occ", occupancy, 0);

    // 2: six back-to-back pairs, three-cycle stall mid-stream
    rec = 1;
    for (int i = 0; i < 6; i++) begin
      drive_pair(20 + i);
      if (i == 4) begin
        stall = 1;
        frozen = out_rt;
        repeat (3) begin
          tick();
          chk("t2_stall_hold", out_rt, frozen);
        end
        stall = 0;
      end
      tick();
    end
    clear_in();
    repeat (DEPTH) tick();
    rec = 0;
    chk("t2_seen_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++) chk("t2_seen_order", seen[i], 20 + i);

    // 3: full pipe, flush kills the two youngest stages
    for (int i = 0; i < 4; i++) begin
      drive_pair(60 + i);
      tick();
    end
    chk("t3_full", occupancy, 8);
    flush = 1;
    drive_pair(70);
    tick();
    flush = 0;
    clear_in();
    chk("t3_occ4", occupancy, 4);
    chk("t3_valid1", out_valid, 2'b11);
    tick();
    chk("t3_occ2", occupancy, 2);
    chk("t3_valid2", out_valid, 2'b11);
    tick();
    chk("t3_occ0", occupancy, 0);
    chk("t3_valid3", out_valid, 0);

    // 4: forwarding priority, wreg=0 never hits, register 0 is ordinary
    drive(0, 1, 1, 9, 128'd1, 0); tick(); clear_in();
    drive(0, 1, 0, 10, 128'h77, 0); tick(); clear_in();
    drive(0, 1, 1, 9, 128'd2, 0); drive(1, 1, 1, 9, 128'd3, 1); tick(); clear_in();
    drive(1, 1, 1, 0, 128'h55, 2); tick(); clear_in();
    lk_addr = {7'd10, 7'd9};
    #1;
`ifdef SPU_RESULT_PIPE_LOOKUP_EN
    hit_exp0 = 128'd3;  hit_exp1 = 128'h55;
`else
    hit_exp0 = '0;      hit_exp1 = '0;
`endif
    chk("t4_hit9", lk_hit[0], hit_exp0 != 0);
    chk("t4_data9", lk_data[DW-1:0], hit_exp0);
    chk("t4_wreg0_miss", lk_hit[1], 0);
    chk("t4_wreg0_data", lk_data[2*DW-1:DW], 0);
    lk_addr = {7'd0, 7'd9};
    drive(0, 1, 1, 9, 128'hEE, 3);
    #1;
    chk("t4_inputs_ignored", lk_data[DW-1:0], hit_exp0);
    chk("t4_addr0_hit", lk_hit[1], hit_exp1 != 0);
    chk("t4_addr0_data", lk_data[2*DW-1:DW], hit_exp1);
    clear_in();
    repeat (DEPTH) tick();
    lk_addr = '0;

    // 5: stalled flush clears in place, then reset overrides stall+flush
    for (int i = 0; i < 4; i++) begin
      drive_pair(80 + i);
      tick();
    end
    clear_in();
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    chk("t5_inplace_occ", occupancy, 4);
    chk("t5_inplace_valid", out_valid, 2'b11);
    for (int i = 0; i < 4; i++) begin
      drive_pair(90 + i);
      tick();
    end
    chk("t5_refull", occupancy, 8);
    lk_addr = {7'd92, 7'd92};
    rst = 1; stall = 1; flush = 1;
    tick();
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_occ", occupancy, 0);
    chk("t5_rst_rt", out_rt, 0);
    chk("t5_rst_addr", out_rtaddr, 0);
    chk("t5_rst_lk", lk_hit, 0);
    rst = 0; stall = 0; flush = 0;
    clear_in();
    tick();
    chk("t5_after_rst", occupancy, 0);
    tick();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
